// File: rtl/topo2a_ad_proj_pkg.sv
// topo2a_ad_proj_pkg: shared widths and state encoding for the dense accumulator.
// Revision: 1.0
`default_nettype none

package topo2a_ad_proj_pkg;

  localparam int ACC_WIDTH  = 32;
  localparam int PROD_WIDTH = 24;
  localparam int OUT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/topo2a_ad_proj_mul_16s_8ns_24.sv
// topo2a_ad_proj_mul_16s_8ns_24: signed 16-bit times unsigned 8-bit, full 24-bit signed product.
// Revision: 1.0
`default_nettype none

module topo2a_ad_proj_mul_16s_8ns_24
  import topo2a_ad_proj_pkg::*;
(
  input  logic [15:0]           a,
  input  logic [7:0]            b,
  output logic [PROD_WIDTH-1:0] p
);

  logic signed [PROD_WIDTH-1:0] a_ext;
  logic signed [PROD_WIDTH-1:0] b_ext;

  // The weight is zero-extended so it stays positive once treated as signed.
  assign a_ext = {{(PROD_WIDTH-16){a[15]}}, a};
  assign b_ext = {{(PROD_WIDTH-8){1'b0}}, b};
  assign p     = a_ext * b_ext;

endmodule

`default_nettype wire

// File: rtl/topo2a_ad_proj_dense_acc.sv
// topo2a_ad_proj_dense_acc: biased multiply-accumulate over a vector of beats, shifted and
// saturated to 16 bits, with a valid/ready handshake on both sides. Revision: 1.0
`default_nettype none

module topo2a_ad_proj_dense_acc
  import topo2a_ad_proj_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int SHIFT = 8
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [7:0]  in_weight,
  input  logic        in_last,
  input  logic [15:0] bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf
);

  localparam int CNT_WIDTH = 9;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = 32'sd32767;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -32'sd32768;

  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]   count;

  logic [PROD_WIDTH-1:0]  prod;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   bias_term;
  logic [ACC_WIDTH-1:0]   acc_nxt;
  logic [CNT_WIDTH-1:0]   count_nxt;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [OUT_WIDTH-1:0]   sat_data;
  logic                   sat_ovf;
  logic                   accept;
  logic                   done;

  topo2a_ad_proj_mul_16s_8ns_24 u_mul (
    .a (in_data),
    .b (in_weight),
    .p (prod)
  );

  assign prod_ext  = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
  assign bias_term = {{(ACC_WIDTH-OUT_WIDTH){bias[OUT_WIDTH-1]}}, bias} << SHIFT;
  assign accept    = in_valid & in_ready;

  always_comb begin
    acc_nxt   = acc + prod_ext;
    count_nxt = count + 1'b1;
    if (state == IDLE) begin
      acc_nxt   = bias_term + prod_ext;
      count_nxt = CNT_WIDTH'(1);
    end
  end

  assign done = in_last | (count_nxt == CNT_WIDTH'(N_IN));

  // Result is derived from the value the accumulator is about to hold, so it
  // can be registered on the final beat and appear one cycle later.
  always_comb begin
    shifted  = $signed(acc_nxt) >>> SHIFT;
    sat_data = shifted[OUT_WIDTH-1:0];
    sat_ovf  = 1'b0;
    if (shifted > SAT_MAX) begin
      sat_data = 16'h7fff;
      sat_ovf  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_data = 16'h8000;
      sat_ovf  = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc   <= acc_nxt;
            count <= count_nxt;
            if (done) begin
              state     <= OUT;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              out_data  <= sat_data;
              out_ovf   <= sat_ovf;
            end else begin
              state <= ACC;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
